bm_noise_mul: RTL and testbench
===============================

// Module: bm_noise_mul
// PURPOSE
//  Box-Muller output stage of the AWGN generator. Consumes the radius term f = sqrt(-2 ln u0)
//  and the cos/sin magnitudes+signs from the trig units. Forms x0 = f*g0 and x1 = f*g1 as
//  signed fixed-point samples and emits them as a serial stream, x0 then x1, under ready/valid.
//  Trig units update on negedge clk; this block samples on posedge (half-cycle path).
// PARAMETERS
//  F_W    17  width of f, unsigned, F_FRAC fraction bits
//  F_FRAC 13  fraction bits of f (Q4.13)
//  G_W    16  width of g0/g1 magnitude, unsigned
//  G_FRAC 15  fraction bits of g (Q1.15, 1.0 = 0x8000)
//  X_W    16  width of output sample, two's complement
//  X_FRAC 11  fraction bits of output (Q5.11); SHIFT = F_FRAC+G_FRAC-X_FRAC = 17
// PORTS
//  clk        in   1       clock; all state on posedge
//  rst        in   1       reset, asynchronous, active-high
//  in_valid   in   1       f/g0/sign0/g1/sign1 hold a valid pair
//  in_ready   out  1       block accepts the pair this cycle
//  f_e        in   F_W     radius term
//  g0         in   G_W     |cos| magnitude
//  sign0      in   1       1 = cos term negative
//  g1         in   G_W     |sin| magnitude
//  sign1      in   1       1 = sin term negative
//  out_valid  out  1       out_data holds a sample
//  out_ready  in   1       sink takes out_data this cycle
//  out_data   out  X_W     noise sample, signed Q5.11
//  out_sel    out  1       0 = sample is x0, 1 = sample is x1
// BEHAVIOUR
//  Reset: in_ready=0 while rst asserted, then 1; out_valid=0, out_data=0, out_sel=0; S1 valid
//   and all pipeline regs cleared; state EMPTY. A reset mid-operation discards in-flight pairs.
//  Stage S1: on accept (in_valid&&in_ready), register p0=f_e*g0, p1=f_e*g1 (F_W+G_W=33 bits,
//   unsigned), sign0, sign1; set v1=1. If no accept but S1 advances, v1 <= 0.
//  Round/saturate (on S1->S2 transfer): m = (p + 2^(SHIFT-1)) >> SHIFT (round half up on
//   magnitude, i.e. symmetric half-away-from-zero after sign). If m > 2^(X_W-1)-1, m = 32767.
//   x = sign ? -m : m. Zero magnitude with sign=1 gives 0x0000. Negative full scale is -32767.
//  Stage S2 output FSM: EMPTY -> SEND0 -> SEND1.
//   EMPTY: out_valid=0. If v1: load x0,x1 into pair buffer -> SEND0.
//   SEND0: out_valid=1, out_data=x0, out_sel=0. out_ready -> SEND1; else hold, data stable.
//   SEND1: out_valid=1, out_data=x1, out_sel=1. out_ready: if v1 load new pair -> SEND0
//    (back-to-back, no bubble), else -> EMPTY. No out_ready: hold.
//  adv = (state==EMPTY) || (state==SEND1 && out_ready). S1->S2 transfer iff v1 && adv.
//  in_ready = !v1 || adv (combinational from state, v1, out_ready).
//  Latency: pair accepted at edge k -> x0 on out_data after edge k+1, x1 after x0 taken.
//  Throughput: one pair per two cycles with out_ready held high; no samples dropped/duplicated.
//  out_valid never deasserts while a sample is pending; out_data/out_sel stable while stalled.
// TESTING
//  f=0x02000,g0=0x8000,s0=0,g1=0x4000,s1=1, out_ready=1 -> 0x0800 (sel0) then 0xFC00 (sel1).
//  f=0x1FFFF,g0=0x8000,s0=0,g1=0x8000,s1=1 -> saturate: 0x7FFF then 0x8001.
//  Rounding: f=0x00001,g0=0x10000-1 style p=0x10000 (half LSB) -> m=1; p=0x0FFFF -> m=0;
//   g=0,sign=1 -> 0x0000.
//  Backpressure: 4 pairs streamed, out_ready random 30% -> 8 samples in order x0,x1 per pair,
//   out_data stable during stalls, in_ready low whenever S1 full and S2 not draining.
//  Continuous: in_valid=1, out_ready=1 for 100 cycles -> out_valid stays 1, sel toggles each
//   cycle, in_ready pulses every other cycle.
//  Assert rst while in SEND0 with v1=1 -> out_valid=0, out_data=0 immediately; after release,
//   next pair's x0 is first output (no stale samples).

Source files
------------

// File: rtl/bm_noise_mul.sv
// Box-Muller output stage: x0 = f*g0, x1 = f*g1 with round/saturate, emitted serially
// as x0 then x1 under ready/valid. Two-stage pipeline: product register, then pair buffer.
`timescale 1ns/1ps
module bm_noise_mul #(
  parameter int F_W    = 17,
  parameter int F_FRAC = 13,
  parameter int G_W    = 16,
  parameter int G_FRAC = 15,
  parameter int X_W    = 16,
  parameter int X_FRAC = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [F_W-1:0] f_e,
  input  logic [G_W-1:0] g0,
  input  logic           sign0,
  input  logic [G_W-1:0] g1,
  input  logic           sign1,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] out_data,
  output logic           out_sel
);

  localparam int SHIFT = F_FRAC + G_FRAC - X_FRAC;
  localparam int P_W   = F_W + G_W;
  localparam logic [P_W:0] HALF    = (P_W+1)'(1) << (SHIFT-1);
  localparam logic [P_W:0] MAX_MAG = (P_W+1)'((1 << (X_W-1)) - 1);

  typedef enum logic [1:0] {EMPTY, SEND0, SEND1} state_t;

  state_t                  state_reg;
  logic                    v1_reg;
  logic [X_W-1:0]          x1_hold_reg;
  logic [1:0][G_W-1:0]     g_in;
  logic [1:0]              s_in;
  logic [1:0][X_W-1:0]     x_next;
  logic                    adv;
  logic                    accept;

  // Round half up on the magnitude, clamp to +full scale, then apply the sign,
  // so the result is symmetric and never reaches -2^(X_W-1).
  function automatic logic [X_W-1:0] round_sat(input logic [P_W-1:0] p_in, input logic neg);
    logic [P_W:0]   m;
    logic [X_W-1:0] mag;
    m   = ({1'b0, p_in} + HALF) >> SHIFT;
    mag = (m > MAX_MAG) ? MAX_MAG[X_W-1:0] : m[X_W-1:0];
    return neg ? -mag : mag;
  endfunction

  assign g_in = {g1, g0};
  assign s_in = {sign1, sign0};

  assign adv      = (state_reg == EMPTY) || (state_reg == SEND1 && out_ready);
  assign in_ready = !rst && (!v1_reg || adv);
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [P_W-1:0] p_reg;
      logic           sign_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_reg    <= '0;
          sign_reg <= 1'b0;
        end else if (accept) begin
          p_reg    <= P_W'(f_e) * P_W'(g_in[gi]);
          sign_reg <= s_in[gi];
        end
      end
      assign x_next[gi] = round_sat(p_reg, sign_reg);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg <= 1'b0;
    end else if (accept) begin
      v1_reg <= 1'b1;
    end else if (v1_reg && adv) begin
      v1_reg <= 1'b0;
    end
  end

  // Output FSM; x0 goes straight to out_data, x1 waits in the hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= EMPTY;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel     <= 1'b0;
      x1_hold_reg <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (v1_reg) begin
            out_data    <= x_next[0];
            x1_hold_reg <= x_next[1];
            out_sel     <= 1'b0;
            out_valid   <= 1'b1;
            state_reg   <= SEND0;
          end
        end
        SEND0: begin
          if (out_ready) begin
            out_data  <= x1_hold_reg;
            out_sel   <= 1'b1;
            state_reg <= SEND1;
          end
        end
        SEND1: begin
          if (out_ready) begin
            if (v1_reg) begin
              out_data    <= x_next[0];
              x1_hold_reg <= x_next[1];
              out_sel     <= 1'b0;
              state_reg   <= SEND0;
            end else begin
              out_valid <= 1'b0;
              state_reg <= EMPTY;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_reg <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bm_noise_mul.sv
// Self-checking bench for bm_noise_mul: directed values, random backpressure, continuous
// streaming and mid-operation reset, scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bm_noise_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] f_e;
  logic [15:0] g0, g1;
  logic        sign0, sign1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sel;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];   // {sel, data}

  bm_noise_mul dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .f_e(f_e), .g0(g0), .sign0(sign0), .g1(g1), .sign1(sign1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  // x = sign * min(round(f*g / 2^17), 32767), with f in Q4.13 and g in Q1.15
  function automatic logic [15:0] model_x(input logic [16:0] f, input logic [15:0] g, input logic s);
    longint p, m;
    p = longint'(f) * longint'(g);
    m = (p + 65536) / 131072;
    if (m > 32767) m = 32767;
    if (s) m = -m;
    return 16'(m);
  endfunction

  task automatic rand_pair();
    f_e   = 17'($urandom_range(0, 131071));
    g0    = 16'($urandom_range(0, 65535));
    g1    = 16'($urandom_range(0, 65535));
    sign0 = 1'($urandom_range(0, 1));
    sign1 = 1'($urandom_range(0, 1));
  endtask

  task automatic push_model();
    exp_q.push_back({1'b0, model_x(f_e, g0, sign0)});
    exp_q.push_back({1'b1, model_x(f_e, g1, sign1)});
  endtask

  // Offers one pair with out_ready high for 8 cycles; reports what came out and when.
  task automatic send_collect(input logic [16:0] f, input logic [15:0] a, input logic sa,
                              input logic [15:0] b, input logic sb, output int n,
                              output logic [16:0] smp0, output logic [16:0] smp1, output int lat);
    int acc_at;
    acc_at = -1; n = 0; smp0 = '0; smp1 = '0; lat = -1;
    f_e = f; g0 = a; sign0 = sa; g1 = b; sign1 = sb; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n == 0) begin smp0 = {out_sel, out_data}; lat = c - acc_at; end
        else if (n == 1) smp1 = {out_sel, out_data};
        n++;
      end
      if (in_valid && in_ready && acc_at < 0) acc_at = c;
      @(posedge clk); #1;
      if (acc_at >= 0) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    f_e = '0; g0 = '0; g1 = '0; sign0 = 1'b0; sign1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_cmp++; if (out_sel !== 1'b0) begin n_fail++; $display("FAIL reset_out_sel: got %b want 0", out_sel); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic [16:0] tf[4]  = '{17'h02000, 17'h1FFFF, 17'h00002, 17'h00001};
    logic [15:0] ta[4]  = '{16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
    logic        tsa[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] tb[4]  = '{16'h4000, 16'h8000, 16'h7FFF, 16'h0000};
    logic        tsb[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] e0[4]  = '{16'h0800, 16'h7FFF, 16'h0001, 16'h0000};
    logic [15:0] e1[4]  = '{16'hFC00, 16'h8001, 16'h0000, 16'h0000};
    int n, lat;
    logic [16:0] s0, s1;
    for (int i = 0; i < 4; i++) begin
      send_collect(tf[i], ta[i], tsa[i], tb[i], tsb[i], n, s0, s1, lat);
      $display("directed[%0d] f=%h g0=%h g1=%h -> %h %h lat=%0d", i, tf[i], ta[i], tb[i], s0, s1, lat);
      n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL dir%0d_count: got %0d want 2", i, n); end
      n_cmp++; if (s0 !== {1'b0, e0[i]}) begin n_fail++; $display("FAIL dir%0d_x0: got %h want %h", i, s0, {1'b0, e0[i]}); end
      n_cmp++; if (s1 !== {1'b1, e1[i]}) begin n_fail++; $display("FAIL dir%0d_x1: got %h want %h", i, s1, {1'b1, e1[i]}); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 2", i, lat); end
      n_cmp++; if (s0[15:0] !== model_x(tf[i], ta[i], tsa[i])) begin n_fail++; $display("FAIL dir%0d_model: got %h want %h", i, s0[15:0], model_x(tf[i], ta[i], tsa[i])); end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, taken = 0, outstanding = 0, cyc = 0;
    logic acc, exp_ir, stalled = 1'b0, held_s = 1'b0;
    logic [15:0] held_d = '0;
    logic [16:0] e;
    exp_q.delete();
    in_valid = 1'b0;
    while ((sent < 4 || taken < 8) && cyc < 400) begin
      out_ready = ($urandom_range(0, 99) < 30);
      if (sent < 4 && !in_valid && $urandom_range(0, 1) == 1) begin rand_pair(); in_valid = 1'b1; end
      @(negedge clk);
      acc = 1'b0;
      exp_ir = (outstanding < 2) || (out_valid && out_sel && out_ready);
      n_cmp++; if (in_ready !== exp_ir) begin n_fail++; $display("FAIL bp_in_ready: got %b want %b cyc=%0d", in_ready, exp_ir, cyc); end
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_sel !== held_s) begin
          n_fail++; $display("FAIL bp_stable: got v=%b %b/%h want v=1 %b/%h", out_valid, out_sel, out_data, held_s, held_d);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %b/%h want none", out_sel, out_data); end
        else begin
          e = exp_q.pop_front();
          $display("bp sample %0d: %b/%h expect %h", taken, out_sel, out_data, e);
          if ({out_sel, out_data} !== e) begin n_fail++; $display("FAIL bp_data: got %h want %h", {out_sel, out_data}, e); end
          if (e[16]) outstanding--;
        end
        taken++;
      end
      if (in_valid && in_ready) begin push_model(); sent++; outstanding++; acc = 1'b1; end
      stalled = out_valid && !out_ready; held_d = out_data; held_s = out_sel;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    n_cmp++; if (cyc >= 400) begin n_fail++; $display("FAIL bp_timeout: got sent=%0d taken=%0d want 4/8", sent, taken); end
    out_ready = 1'b0;
  endtask

  task automatic test_continuous();
    int outstanding = 0;
    logic acc, exp_ir, prev_sel = 1'b0;
    logic [16:0] e;
    exp_q.delete();
    rand_pair(); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      acc = 1'b0;
      exp_ir = (outstanding < 2) || (out_valid && out_sel && out_ready);
      n_cmp++; if (in_ready !== exp_ir) begin n_fail++; $display("FAIL cont_in_ready: got %b want %b c=%0d", in_ready, exp_ir, c); end
      if (c >= 2) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid: got %b want 1 c=%0d", out_valid, c); end
        n_cmp++; if (in_ready !== out_sel) begin n_fail++; $display("FAIL cont_pulse: got in_ready=%b want %b c=%0d", in_ready, out_sel, c); end
      end
      if (c >= 3) begin
        n_cmp++; if (out_sel !== ~prev_sel) begin n_fail++; $display("FAIL cont_toggle: got %b want %b c=%0d", out_sel, ~prev_sel, c); end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL cont_extra: got %h want none", out_data); end
        else begin
          e = exp_q.pop_front();
          if ({out_sel, out_data} !== e) begin n_fail++; $display("FAIL cont_data: got %h want %h", {out_sel, out_data}, e); end
          if (e[16]) outstanding--;
        end
      end
      if (in_valid && in_ready) begin push_model(); outstanding++; acc = 1'b1; end
      prev_sel = out_sel;
      @(posedge clk); #1;
      if (acc) rand_pair();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_cmp++; if ({out_sel, out_data} !== e) begin n_fail++; $display("FAIL cont_drain: got %h want %h", {out_sel, out_data}, e); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cont_drain_left: got %0d want 0", exp_q.size()); end
    $display("test_continuous done");
  endtask

  task automatic test_reset_mid();
    int acc = 0, n, lat;
    logic a;
    logic [16:0] s0, s1, f;
    logic [15:0] ga, gb;
    logic sa, sb;
    out_ready = 1'b0;
    rand_pair(); in_valid = 1'b1;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      @(negedge clk);
      a = in_valid && in_ready;
      if (a) acc++;
      @(posedge clk); #1;
      if (a) rand_pair();
    end
    in_valid = 1'b0;
    n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL rmid_fill: got %0d want 2", acc); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 1'b0) begin n_fail++; $display("FAIL rmid_pending: got v=%b sel=%b want 1/0", out_valid, out_sel); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got %b want 0", in_ready); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_data: got %h want 0000", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    f = 17'($urandom_range(0, 131071)); ga = 16'($urandom_range(0, 65535)); gb = 16'($urandom_range(0, 65535));
    sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
    send_collect(f, ga, sa, gb, sb, n, s0, s1, lat);
    $display("reset_mid fresh pair -> %h %h n=%0d", s0, s1, n);
    n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL rmid_count: got %0d want 2", n); end
    n_cmp++; if (s0 !== {1'b0, model_x(f, ga, sa)}) begin n_fail++; $display("FAIL rmid_x0: got %h want %h", s0, {1'b0, model_x(f, ga, sa)}); end
    n_cmp++; if (s1 !== {1'b1, model_x(f, gb, sb)}) begin n_fail++; $display("FAIL rmid_x1: got %h want %h", s1, {1'b1, model_x(f, gb, sb)}); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_continuous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish by 500000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
